// File: rtl/mux_pkg.sv
// Shared constants for the round-robin operand mux.
// Default geometry and mode encodings.
package mux_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter for mux_rr_nch.
// Searches upward from ptr; ptr advances past each RR winner.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  localparam int CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_i,
  input  logic           upd_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CW-1:0]  idx_o
);

  logic [CW-1:0] ptr_q, ptr_d;

  // first requester at or above ptr, wrapping modulo NCH
  always_comb begin
    int   c;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NCH; k++) begin
      c = (int'(ptr_q) + k) % NCH;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = CW'(c);
      end
    end
  end

  // step ptr just past the winner, wrapping explicitly at NCH-1
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      if (int'(idx_o) == NCH - 1)
        ptr_d = '0;
      else
        ptr_d = idx_o + CW'(1);
    end
  end

  // priority pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_rr_nch.sv
// N-channel registered operand mux, fixed or round-robin.
// Single output stage with valid/ready on every side.
module mux_rr_nch
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  localparam int CW   = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [CW-1:0]      sel,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]     in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_ch,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;

  logic [NCH-1:0]   rr_gnt, fix_gnt, gnt;
  logic [CW-1:0]    rr_idx, g;
  logic [WIDTH-1:0] g_data;
  logic             load, any;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (in_valid),
    .upd_i (mode == MODE_RR && load && any),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // fixed-select grant; an out-of-range sel matches no channel
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < NCH; i++)
      if (int'(sel) == i && in_valid[i])
        fix_gnt[i] = 1'b1;
  end

  assign gnt  = (mode == MODE_RR) ? rr_gnt : fix_gnt;
  assign g    = (mode == MODE_RR) ? rr_idx : sel;
  assign any  = |gnt;
  assign load = !out_valid_q || out_ready;

  // ready is held low during reset so nothing appears accepted
  assign in_ready = (load && !rst) ? gnt : '0;

  // pick the granted channel's word
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NCH; i++)
      if (int'(g) == i)
        g_data = in_data[i*WIDTH +: WIDTH];
  end

  // output stage: refill on grant, empty when nothing granted
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = g_data;
        out_ch_d   = g;
      end
    end
  end

  // output register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_nch.sv
// Directed bench for mux_rr_nch.
// Main instance NCH=4, side instance NCH=8 for sel range.
module tb_mux_rr_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        mode8;
  logic [2:0]  sel8;
  logic [7:0]  in_valid8;
  logic [127:0] in_data8;
  logic [7:0]  in_ready8;
  logic        out_valid8;
  logic [15:0] out_data8;
  logic [2:0]  out_ch8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_rr_nch #(.WIDTH(16), .NCH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  mux_rr_nch #(.WIDTH(16), .NCH(8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .sel(sel8),
    .in_valid(in_valid8), .in_data(in_data8),
    .in_ready(in_ready8), .out_valid(out_valid8),
    .out_data(out_data8), .out_ch(out_ch8),
    .out_ready(1'b1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [1:0] c,
                         input logic [15:0] d);
    chk({tag, ".v"}, 32'(out_valid), 32'(v));
    chk({tag, ".ch"}, 32'(out_ch), 32'(c));
    chk({tag, ".d"}, 32'(out_data), 32'(d));
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    out_ready = 1'b1;
    mode8     = 1'b0;
    sel8      = 3'd7;
    in_valid8 = 8'h0F;
    in_data8  = '0;

    // reset with every channel valid
    @(posedge clk);
    #3;
    chk_out("rst", 1'b0, 2'd0, 16'h0000);
    chk("rst.rdy", 32'(in_ready), 32'h0);
    chk("rst.rdy8", 32'(in_ready8), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.rdy", 32'(in_ready), 32'b0001);

    // round-robin fairness, no bubbles
    step(); chk_out("rr0", 1'b1, 2'd0, 16'h0000);
    step(); chk_out("rr1", 1'b1, 2'd1, 16'h1111);
    step(); chk_out("rr2", 1'b1, 2'd2, 16'h2222);
    step(); chk_out("rr3", 1'b1, 2'd3, 16'h3333);
    step(); chk_out("rr4", 1'b1, 2'd0, 16'h0000);
    step(); chk_out("rr5", 1'b1, 2'd1, 16'h1111);

    // backpressure holding the ch1 word
    out_ready = 1'b0;
    #1;
    chk("bp.rdy0", 32'(in_ready), 32'h0);
    step(); chk_out("bp1", 1'b1, 2'd1, 16'h1111);
    step(); chk_out("bp2", 1'b1, 2'd1, 16'h1111);
    step(); chk_out("bp3", 1'b1, 2'd1, 16'h1111);
    chk("bp.rdy3", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp.rel", 32'(in_ready), 32'b0100);
    step(); chk_out("bp.refill", 1'b1, 2'd2, 16'h2222);

    // fixed mode, sel=2
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data[47:32] = 16'hA5A5;
    #1;
    chk("fx.rdy", 32'(in_ready), 32'b0100);
    step(); chk_out("fx", 1'b1, 2'd2, 16'hA5A5);

    // fixed transfer left ptr at 3
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("fx.ptr", 32'(in_ready), 32'b1000);

    // sparse RR: take ch0 to put ptr at 1
    in_valid = 4'b0001;
    #1;
    step(); chk_out("sp.ch0", 1'b1, 2'd0, 16'h0000);
    in_valid = 4'b1001;
    #1;
    chk("sp.rdy3", 32'(in_ready), 32'b1000);
    step(); chk_out("sp.ch3", 1'b1, 2'd3, 16'h3333);
    chk("sp.rdy0", 32'(in_ready), 32'b0001);
    step(); chk_out("sp.wrap", 1'b1, 2'd0, 16'h0000);

    // drain with no input valid
    in_valid = 4'b0000;
    step(); chk_out("drain", 1'b0, 2'd0, 16'h0000);

    // fixed sel on the 8-channel build
    chk("s8.sel7", 32'(in_ready8), 32'h00);
    sel8 = 3'd3;
    #1;
    chk("s8.sel3", 32'(in_ready8), 32'h08);

    // mid-stream reset while stalled
    in_valid = 4'b1111;
    #1;
    step(); chk_out("mr.load", 1'b1, 2'd1, 16'h1111);
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    step(); chk_out("mr.hold", 1'b1, 2'd1, 16'h1111);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mr.rst", 1'b0, 2'd0, 16'h0000);
    rst      = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("mr.ptr", 32'(in_ready), 32'b0001);
    step(); chk_out("mr.first", 1'b1, 2'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
